uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive stage that consumes the bit stream produced by the baud-rate transmit stage and recovers bytes from it. Synchronises the asynchronous line, detects a start bit, samples each bit at its centre using a `CLKS_PER_BIT` divider, and checks the stop bit. Delivers each byte on a valid/ready interface to the downstream consumer, and flags framing and overrun errors.

## Interface
- `CLKS_PER_BIT`, default 414: clock cycles per serial bit. Matches the transmit stage's count. Legal range is 4..65535.
- `CLKIN`  in  1  system clock; all logic is on the rising edge.
- `RESETN`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line. It idles high and is asynchronous to `CLKIN`.
- `data`  out  8  received byte. Valid while `valid` is 1. Reset value 0.
- `valid`  out  1  byte available. Reset value 0.
- `ready`  in  1  consumer accepts the byte; a transfer occurs when `valid && ready`.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0. Reset value 0.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped because `valid` is still 1. Reset value 0.
- `parity_err`  out  1  one-cycle pulse when parity fails. Reset value 0. Tied 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- **Synchroniser**
  - `rx` passes through a 2-flop synchroniser; both flops reset to 1.
  - The synchronised line is called `rxs`. A third flop holds `rxs_d`, also reset to 1.
- **State machine:** states IDLE, START, DATA, PARITY (macro only), STOP. Reset state is IDLE.
- **IDLE**
  - A falling edge (`rxs_d==1 && rxs==0`) loads the counter with `CLKS_PER_BIT/2 - 1` (floor) and moves to START.
- **START**
  - When the counter reaches 0, sample `rxs`.
  - If the sample is 0: load `CLKS_PER_BIT-1`, clear the bit index, go to DATA.
  - If the sample is 1: false start; return to IDLE with no output.
- **DATA**
  - At each counter expiry, shift `rxs` into the shift register LSB-first and reload `CLKS_PER_BIT-1`.
  - After 8 bits, go to PARITY (macro) or STOP.
- **PARITY**
  - At counter expiry, compare the sample with the even parity of the 8 data bits. Record the result and go to STOP.
- **STOP**
  - At counter expiry, sample `rxs` and go to IDLE on the same edge. The FSM does not wait out the stop bit, so back-to-back frames are received.
  - Sample 0: pulse `frame_err`; the byte is discarded.
  - Parity mismatch (macro only): pulse `parity_err`; the byte is discarded.
  - Sample 1 with `valid==0`, or with `valid && ready` in the same cycle: load `data` and set `valid`.
  - Sample 1 with `valid==1` and `ready==0`: pulse `overrun`. The old `data` is retained and the new byte is dropped.
- **Output handshake**
  - `valid` clears on the cycle after `valid && ready`.
  - `data` is stable while `valid` is 1.
  - `ready` while `valid==0` has no effect.
- **Counter**
  - Width is `$clog2(CLKS_PER_BIT)`. It counts down; expiry is when it equals 0.
  - It never wraps: it is always reloaded on expiry.
- **Reset**
  - Asserting `RESETN` mid-frame returns the FSM to IDLE, clears `valid`, `data` and the error outputs, and sets the synchroniser flops to 1.
  - After release, the partial frame is ignored until a fresh falling edge.

## Timing
- `rx` to `rxs` latency is 2 cycles. The edge is detected in the cycle `rxs` first reads 0; call that cycle T.
- Sample points:
  - start bit at T + `CLKS_PER_BIT/2`
  - data bit k (0..7) at T + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`
  - stop bit at T + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` (+`CLKS_PER_BIT` with parity)
- `valid`, `frame_err`, `overrun` and `parity_err` assert on the cycle after the stop sample.
- The earliest next-frame edge detection is the cycle after the stop sample.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** the frame carries one even-parity bit after D7, the PARITY state exists, and `parity_err` is driven as described above.
- **Undefined:** no PARITY state, the frame is 8N1, and `parity_err` is constant 0.

## Structure
- Package `uart_pkg` holds:
  - the `uart_rx_state_t` enum
  - `UART_DATA_BITS = 8`
  - `UART_IDLE_LEVEL = 1'b1`
  - a shared even-parity function, also used by the transmit side
- Sub-module `uart_rx_sync`: 2-flop synchroniser plus delay flop, reset to 1, with outputs `rxs` and `rxs_d`.

## Test plan
All scenarios run with `CLKS_PER_BIT=16`.
- **Single byte:** drive 0xA5 as 8N1 with `ready`=1 → `valid` pulses 1 cycle with `data`=0xA5. Stop-bit sampling lands at T+8+144.
- **Glitch:** a 4-cycle low glitch on idle `rx` → FSM returns to IDLE from START; no `valid` and no error pulses.
- **Framing error:** send 0x3C with the stop bit held 0 → one-cycle `frame_err`, `valid` stays 0, and the next good frame 0x11 is received correctly.
- **Overrun:** two back-to-back frames 0x01 and 0x02 with `ready`=0 → `data`=0x01 is held and `overrun` pulses once. After `ready`=1, `valid` drops the next cycle.
- **Reset mid-frame:** pulse `RESETN` low during DATA bit 3 → all outputs 0. The remaining bits of that frame produce no `valid`; the following frame 0x7E is received.
- **Parity (with `UART_RX_PARITY_EN`):** 0x07 with parity bit 1 → `data`=0x07. The same byte with parity bit 0 → `parity_err` pulse and no `valid`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types, constants and the even-parity helper used by both directions.
// UART_RX_PARITY_EN adds the PARITY receive state.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } uart_rx_state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-delivery side of the UART receiver: valid/ready handshake plus error pulses.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data;
    logic                      valid;
    logic                      ready;
    logic                      frame_err;
    logic                      overrun;
    logic                      parity_err;

    modport master (
        output data, valid, frame_err, overrun, parity_err,
        input  ready
    );

    modport slave (
        input  data, valid, frame_err, overrun, parity_err,
        output ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus one delay flop for edge detection.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rxs,
    output logic rxs_d
);

    logic meta_q;
    logic rxs_q;
    logic rxs_dly_q;

    // All flops reset to the idle level so a reset never looks like a start edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q    <= UART_IDLE_LEVEL;
            rxs_q     <= UART_IDLE_LEVEL;
            rxs_dly_q <= UART_IDLE_LEVEL;
        end else begin
            meta_q    <= rx_i;
            rxs_q     <= meta_q;
            rxs_dly_q <= rxs_q;
        end
    end

    assign rxs   = rxs_q;
    assign rxs_d = rxs_dly_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-samples 8N1 frames (8E1 with UART_RX_PARITY_EN) and delivers
// bytes on a valid/ready interface with framing, overrun and parity error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 414
) (
    input  logic      CLKIN,
    input  logic      RESETN,
    input  logic      rx,
    uart_rx_if.master rx_if
);

    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic rxs;
    logic rxs_d;

    uart_rx_sync u_sync (
        .clk_i (CLKIN),
        .rst_ni(RESETN),
        .rx_i  (rx),
        .rxs   (rxs),
        .rxs_d (rxs_d)
    );

    uart_rx_state_t            state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      frame_err_q;
    logic                      overrun_q;
`ifdef UART_RX_PARITY_EN
    logic                      parity_err_q;
    logic                      parity_bad_q;
`endif

    logic cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    // The stop sample returns to IDLE immediately so a back-to-back start edge is not missed.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            parity_bad_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (valid_q && rx_if.ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                RX_IDLE: begin
                    if (rxs_d && !rxs) begin
                        cnt_q   <= HALF_LOAD;
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (!rxs) begin
                        cnt_q     <= BIT_LOAD;
                        bit_idx_q <= '0;
                        state_q   <= RX_DATA;
                    end else begin
                        state_q <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        shift_q   <= {rxs, shift_q[UART_DATA_BITS-1:1]};
                        cnt_q     <= BIT_LOAD;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= RX_PARITY;
`else
                            state_q <= RX_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        parity_bad_q <= (rxs != even_parity(shift_q));
                        cnt_q        <= BIT_LOAD;
                        state_q      <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        state_q <= RX_IDLE;
                        if (!rxs) begin
                            frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad_q) begin
                            parity_err_q <= 1'b1;
`endif
                        end else if (!valid_q || rx_if.ready) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_if.data      = data_q;
    assign rx_if.valid     = valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = parity_err_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; frames are built bit by bit
// and outcomes are predicted from the frame contents and handshake state.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic CLKIN  = 1'b0;
    logic RESETN = 1'b0;
    logic rx     = 1'b1;

    uart_rx_if rxIf ();

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .CLKIN (CLKIN),
        .RESETN(RESETN),
        .rx    (rx),
        .rx_if (rxIf)
    );

    always #5 CLKIN = ~CLKIN;

    int cyc = 0;
    always @(posedge CLKIN) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    int         validCycles = 0;
    int         feCycles = 0;
    int         ovCycles = 0;
    int         peCycles = 0;
    int         lastValidRise = 0;
    logic       validPrev = 1'b0;
    logic [7:0] xferQ[$];

    // Observes the output side at the falling edge, away from the active edge.
    always @(negedge CLKIN) begin
        if (RESETN) begin
            if (rxIf.valid) validCycles++;
            if (rxIf.valid && !validPrev) lastValidRise = cyc;
            if (rxIf.valid && rxIf.ready) xferQ.push_back(rxIf.data);
            if (rxIf.frame_err) feCycles++;
            if (rxIf.overrun) ovCycles++;
            if (rxIf.parity_err) peCycles++;
        end
        validPrev = rxIf.valid;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLKIN);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic parBit);
        rx = 1'b0;
        idle(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(C);
        end
        if (PAR_BITS != 0) begin
            rx = parBit;
            idle(C);
        end
        rx = stopBit;
        idle(C);
        rx = 1'b1;
    endtask

    function automatic logic evenPar(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return logic'(ones % 2);
    endfunction

    // Start-bit drive to first valid cycle: sync delay, half bit, 9 (or 10) full bits, output register.
    function automatic int frameLatency();
        return 2 + C / 2 + (9 + PAR_BITS) * C + 1;
    endfunction

    function automatic logic [31:0] headOf();
        return (xferQ.size() > 0) ? 32'(xferQ[0]) : 32'hDEAD;
    endfunction

    initial begin
        int         startCyc;
        int         vBase;
        int         feBase;
        int         ovBase;
        logic [7:0] b;
        logic [7:0] expQ[$];

        rxIf.ready = 1'b0;
        RESETN     = 1'b0;
        idle(3);
        checkOutput("reset_valid", 32'(rxIf.valid), 32'd0);
        checkOutput("reset_data", 32'(rxIf.data), 32'd0);
        checkOutput("reset_frame_err", 32'(rxIf.frame_err), 32'd0);
        checkOutput("reset_overrun", 32'(rxIf.overrun), 32'd0);
        checkOutput("reset_parity_err", 32'(rxIf.parity_err), 32'd0);
        RESETN = 1'b1;
        idle(5);

        rxIf.ready = 1'b1;
        xferQ.delete();
        vBase    = validCycles;
        startCyc = cyc;
        applyStimulus(8'hA5, 1'b1, evenPar(8'hA5));
        idle(4);
        checkOutput("single_latency", 32'(lastValidRise - startCyc), 32'(frameLatency()));
        checkOutput("single_count", 32'(xferQ.size()), 32'd1);
        checkOutput("single_data", headOf(), 32'hA5);
        checkOutput("single_pulse_width", 32'(validCycles - vBase), 32'd1);

        vBase  = validCycles;
        feBase = feCycles;
        ovBase = ovCycles;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(3 * C);
        checkOutput("glitch_valid", 32'(validCycles - vBase), 32'd0);
        checkOutput("glitch_errors", 32'(feCycles - feBase + ovCycles - ovBase), 32'd0);

        vBase  = validCycles;
        feBase = feCycles;
        applyStimulus(8'h3C, 1'b0, evenPar(8'h3C));
        idle(C);
        checkOutput("frame_err_pulse", 32'(feCycles - feBase), 32'd1);
        checkOutput("frame_err_no_valid", 32'(validCycles - vBase), 32'd0);
        xferQ.delete();
        applyStimulus(8'h11, 1'b1, evenPar(8'h11));
        idle(4);
        checkOutput("after_frame_err_count", 32'(xferQ.size()), 32'd1);
        checkOutput("after_frame_err_data", headOf(), 32'h11);

        rxIf.ready = 1'b0;
        xferQ.delete();
        ovBase = ovCycles;
        applyStimulus(8'h01, 1'b1, evenPar(8'h01));
        applyStimulus(8'h02, 1'b1, evenPar(8'h02));
        idle(4);
        checkOutput("overrun_valid_held", 32'(rxIf.valid), 32'd1);
        checkOutput("overrun_data_held", 32'(rxIf.data), 32'h01);
        checkOutput("overrun_pulse", 32'(ovCycles - ovBase), 32'd1);
        rxIf.ready = 1'b1;
        idle(1);
        checkOutput("overrun_valid_drop", 32'(rxIf.valid), 32'd0);
        checkOutput("overrun_xfer_count", 32'(xferQ.size()), 32'd1);
        checkOutput("overrun_xfer_data", headOf(), 32'h01);

        rxIf.ready = 1'b0;
        applyStimulus(8'h5A, 1'b1, evenPar(8'h5A));
        idle(4);
        checkOutput("pre_reset_valid", 32'(rxIf.valid), 32'd1);
        fork
            applyStimulus(8'hFA, 1'b1, evenPar(8'hFA));
            begin
                idle(4 * C + C / 2);
                RESETN = 1'b0;
                #1;
                checkOutput("midreset_valid", 32'(rxIf.valid), 32'd0);
                checkOutput("midreset_data", 32'(rxIf.data), 32'd0);
                checkOutput("midreset_frame_err", 32'(rxIf.frame_err), 32'd0);
                checkOutput("midreset_overrun", 32'(rxIf.overrun), 32'd0);
                idle(2);
                RESETN = 1'b1;
                vBase = validCycles;
            end
        join
        idle(C);
        checkOutput("midreset_partial_ignored", 32'(validCycles - vBase), 32'd0);
        rxIf.ready = 1'b1;
        xferQ.delete();
        applyStimulus(8'h7E, 1'b1, evenPar(8'h7E));
        idle(4);
        checkOutput("post_reset_count", 32'(xferQ.size()), 32'd1);
        checkOutput("post_reset_data", headOf(), 32'h7E);

        xferQ.delete();
        expQ.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            applyStimulus(b, 1'b1, evenPar(b));
            expQ.push_back(b);
            idle($urandom_range(0, 5));
        end
        idle(4);
        checkOutput("rand_count", 32'(xferQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput("rand_data", (i < xferQ.size()) ? 32'(xferQ[i]) : 32'hDEAD, 32'(expQ[i]));
        end

`ifdef UART_RX_PARITY_EN
        xferQ.delete();
        applyStimulus(8'h07, 1'b1, 1'b1);
        idle(4);
        checkOutput("parity_good_count", 32'(xferQ.size()), 32'd1);
        checkOutput("parity_good_data", headOf(), 32'h07);
        applyStimulus(8'h07, 1'b1, 1'b0);
        idle(4);
        checkOutput("parity_err_pulse", 32'(peCycles), 32'd1);
        checkOutput("parity_err_no_valid", 32'(xferQ.size()), 32'd1);
`else
        checkOutput("parity_err_tied_low", 32'(peCycles), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
